width_unpack_reader: RTL

Read-side controller for the width-translating dual-port RAM. It owns the read port: it issues `rden`/`raddr` while the RAM holds unread words, and captures each WRDATA_SIZE-bit word one cycle later. It repacks the words LSB-first into an RDDATA_SIZE-bit stream with a valid/ready handshake. It sits in the `rdclk` domain; the write pointer it compares against is already in this domain.

---
 rtl/width_unpack_reader_if.sv | 24 ++
 rtl/width_unpack_reader.sv | 73 +++++++
 2 files changed

// File: rtl/width_unpack_reader_if.sv
// RAM read port and repacked output stream of the width-unpacking reader.
// master = reader side, slave = RAM + consumer side.
interface width_unpack_reader_if #(
    parameter int WRDATA_SIZE = 4,
    parameter int RDDATA_SIZE = 3,
    parameter int ADDR_SIZE   = 4
);
    logic                   rden;
    logic [ADDR_SIZE-1:0]   raddr;
    logic [WRDATA_SIZE-1:0] rdata;
    logic [RDDATA_SIZE-1:0] dout;
    logic                   dout_valid;
    logic                   dout_ready;

    modport master (
        output rden, raddr, dout, dout_valid,
        input  rdata, dout_ready
    );

    modport slave (
        input  rden, raddr, dout, dout_valid,
        output rdata, dout_ready
    );
endinterface

// File: rtl/width_unpack_reader.sv
// Read-side controller: fetches WRDATA_SIZE-bit RAM words and repacks them
// LSB-first into RDDATA_SIZE-bit chunks with a valid/ready handshake.
module width_unpack_reader #(
    parameter int WRDATA_SIZE = 4,
    parameter int RDDATA_SIZE = 3,
    parameter int ADDR_SIZE   = 4
) (
    input  logic                                   rdclk,
    input  logic                                   rst,
    input  logic [ADDR_SIZE:0]                     wr_ptr,
    output logic [ADDR_SIZE:0]                     rd_ptr,
    output logic                                   empty,
    output logic [$clog2(WRDATA_SIZE+RDDATA_SIZE)-1:0] bit_cnt,
    width_unpack_reader_if.master                  bus
);
    localparam int ACC_W = WRDATA_SIZE + RDDATA_SIZE - 1;
    localparam int BCW   = $clog2(WRDATA_SIZE + RDDATA_SIZE);
    localparam int PW    = ADDR_SIZE + 1;
    localparam logic [BCW-1:0] RD_C = BCW'(RDDATA_SIZE);
    localparam logic [BCW-1:0] WR_C = BCW'(WRDATA_SIZE);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [ACC_W-1:0] acc_q;
    logic [BCW-1:0]   bit_cnt_q;

    logic fetch;
    logic pop;

    assign empty = (rd_ptr_q == wr_ptr);
    // Fetch only while the accumulator cannot yet form a chunk, so a merged
    // word always fits in ACC_W bits and never collides with a pop.
    assign fetch = (state_q == IDLE) && (bit_cnt_q < RD_C) && !empty;
    assign pop   = bus.dout_valid && bus.dout_ready;

    assign bus.rden       = fetch & ~rst;
    assign bus.raddr      = rd_ptr_q[ADDR_SIZE-1:0];
    assign bus.dout       = acc_q[RDDATA_SIZE-1:0];
    assign bus.dout_valid = (bit_cnt_q >= RD_C);

    assign rd_ptr  = rd_ptr_q;
    assign bit_cnt = bit_cnt_q;

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            acc_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch) begin
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                        state_q  <= WAIT;
                    end else if (pop) begin
                        acc_q     <= acc_q >> RDDATA_SIZE;
                        bit_cnt_q <= bit_cnt_q - RD_C;
                    end
                end
                WAIT: begin
                    // Bits at and above bit_cnt are zero, so OR places the word.
                    acc_q     <= acc_q | (ACC_W'(bus.rdata) << bit_cnt_q);
                    bit_cnt_q <= bit_cnt_q + WR_C;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
